seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode 7-segment display. Latches a packed BCD word with per-digit decimal-point and blank masks, scans one digit per slot with anti-ghosting dead time, and commits new data only at frame boundaries so the display never tears. It sits between the clock/countdown datapath and the board's segment and anode pins, and replaces per-digit combinational decoders.

## Interface
- DIGITS, 4: number of digits, legal range 1..8.
- SCAN_DIV, 100000: clk cycles per digit slot, minimum 4.
- DEAD_CYC, 4: blanked cycles at the start of each slot, 1 ≤ DEAD_CYC < SCAN_DIV.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- bcd_in  in  4*DIGITS  packed digit codes; digit 0 is bits [3:0] and is least significant / rightmost.
- dp_in  in  DIGITS  decimal point per digit; 1 = lit.
- blank_in  in  DIGITS  force digit dark; 1 = blank.
- load  in  1  one-cycle strobe that captures bcd_in, dp_in and blank_in.
- seg  out  8  bit 7..1 = segments a..g, bit 0 = dp; active-low (0 = lit).
- an  out  DIGITS  anode enables; active-low; at most one bit is 0 at any time.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- Code map, active-low a..g,dp:
  - 0 = 0000001x, 1 = 1001111x, 2 = 0010010x, 3 = 0000110x, 4 = 1001100x.
  - 5 = 0100100x, 6 = 0100000x, 7 = 0001111x, 8 = 0000000x, 9 = 0000100x.
  - 11 = dash, 1111110x.
  - 10 and 12..15 = blank, 1111111x.
  - The dp bit x is ~dp for the digit being shown.
- blank_in overrides both the code and dp, giving seg = 8'hFF.
- Registers:
  - staging holds the last load.
  - shadow holds the data being displayed.
  - pending flag.
  - slot counter cnt, width clog2(SCAN_DIV).
  - digit index idx, width clog2(DIGITS) with a minimum of 1.
- cnt counts 0..SCAN_DIV-1 and wraps. A wrap is the "tick". On a tick, idx increments and wraps from DIGITS-1 to 0.
- A tick with idx == DIGITS-1 is the frame boundary. At the frame boundary:
  - if pending, staging is copied to shadow and pending clears;
  - frame_done is 1 in the following cycle.
- load writes staging and sets pending.
- load in the same cycle as a frame boundary: shadow takes the previous staging contents, staging takes the new data, and pending remains 1. The new data displays one frame later.
- Scan states per slot:
  - DEAD (cnt < DEAD_CYC): an = all 1, seg = 8'hFF.
  - ON: an = ~(1 << idx), seg = decode(shadow[idx]).
- All outputs are registered. an and seg change in the same cycle.

## Timing
- Reset values, applied immediately and asynchronously:
  - seg = 8'hFF, an = all 1, frame_done = 0.
  - cnt = 0, idx = 0, pending = 0.
  - staging and shadow: codes = 4'hF (blank), dp = 0, blank = all 1.
- Output latency: outputs reflect cnt/idx state one cycle later (registered decode).
- After reset release, idx 0 is in DEAD for DEAD_CYC cycles, then ON for SCAN_DIV-DEAD_CYC cycles.
- Frame period is DIGITS*SCAN_DIV cycles.
- Load-to-display latency: up to 1 frame plus 1 cycle (2 frames when load coincides with a boundary).
- Reset asserted mid-frame discards staging, shadow and pending; the display goes dark the same instant.
- DIGITS = 1: every tick is a frame boundary.

## Configuration
- SEG_LZ_SUPPRESS_EN defined: leading-zero suppression.
  - A code-0 digit renders blank when every more-significant digit is code 0 or blanked.
  - Digit 0 is never suppressed.
  - dp on a suppressed digit is still shown.
  - Evaluation uses shadow contents only.
- SEG_LZ_SUPPRESS_EN undefined: zeros always display. No suppression logic is synthesised.

## Structure
- The shared include/package holds:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - code values CODE_DASH = 11, CODE_BLANK = 15;
  - the segment bit-order definition.
- Sub-module seg_digit_decode: combinational 4-bit code + dp + blank → 8-bit seg. The top instantiates it once, on the muxed digit.

## Test plan
- **Reset:** assert rst mid-ON slot → same cycle an = 1111, seg = FF, frame_done = 0; after release with no load, the display stays dark.
- **Scan order:** DIGITS = 4, SCAN_DIV = 8, DEAD_CYC = 2, load 16'h1234, wait for the boundary.
  - Slot idx0: 2 cycles an = 1111, then 6 cycles an = 1110, seg = 10011001 (code 4, dp off).
  - idx1 follows with an = 1101, seg = 00001101 (code 3), then idx2 (code 2) and idx3 (code 1).
- **Tear-free update:** load 16'h5678 at mid-frame → rest of the current frame still shows 1234.
  - After the boundary the display shows 5678.
  - frame_done is a single-cycle pulse every 32 cycles.
- **Boundary collision:** load A one frame before, then load B in the boundary cycle → next frame shows A, the following frame shows B.
- **Codes, dp, blank:**
  - code 11 → seg 11111101; code 13 → FF.
  - dp_in[0] = 1 on code 8 → 00000000.
  - blank_in[0] = 1 with dp_in[0] = 1 → FF.
- **Leading zeros:** load 16'h0070.
  - Macro defined: digits 3 and 2 show FF, digit 1 shows 0001111x, digit 0 shows 0000001x.
  - Macro undefined: digit 3 shows 0000001x.
  - Load 16'h0000 with macro: only digit 0 lit.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment encoding for the 7-segment scan driver: code values, active-low a..g patterns, bit order.
// Pure constants; no latency, no backpressure.
package seg7_scan_driver_pkg;

    localparam int SEG_W      = 8;
    // seg[7:1] carries segments a..g (a in the MSB), seg[0] carries the decimal point
    localparam int SEG_BIT_A  = 7;
    localparam int SEG_BIT_DP = 0;

    localparam logic [3:0] CODE_DASH  = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display data in (packed BCD, dp and blank masks, load strobe) and segment/anode pins out.
// Master drives the data, slave is the scan driver; load is always accepted, no backpressure.
interface seg7_scan_driver_if
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic [SEG_W-1:0]    seg;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output bcd_in, dp_in, blank_in, load,
        input  seg, an, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, blank_in, load,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver_seg_digit_decode.sv
// Combinational code + dp + blank to active-low segment byte (a..g, dp).
// Zero latency, no backpressure.
module seg_digit_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0]       code_i,
    input  logic             dp_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);
    logic [6:0] segs;

    always_comb begin
        case (code_i)
            4'd0:      segs = SEG_0;
            4'd1:      segs = SEG_1;
            4'd2:      segs = SEG_2;
            4'd3:      segs = SEG_3;
            4'd4:      segs = SEG_4;
            4'd5:      segs = SEG_5;
            4'd6:      segs = SEG_6;
            4'd7:      segs = SEG_7;
            4'd8:      segs = SEG_8;
            4'd9:      segs = SEG_9;
            CODE_DASH: segs = SEG_DASH;
            default:   segs = SEG_BLANK;
        endcase
        seg_o = '1;
        if (!blank_i) begin
            seg_o[SEG_BIT_A -: 7] = segs;
            seg_o[SEG_BIT_DP]     = ~dp_i;
        end
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Tear-free multiplexed 7-segment driver; outputs registered (1 cycle after cnt/idx), load never stalled.
// SEG_LZ_SUPPRESS_EN enables leading-zero suppression on the displayed (shadow) data.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DEAD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_DEAD = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] BCD_RST  = {DIGITS{CODE_BLANK}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] stg_bcd_q, stg_bcd_d, shd_bcd_q, shd_bcd_d;
    logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [DIGITS-1:0]   stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q, fd_d;

    logic             tick, boundary;
    logic [3:0]       cur_code, dec_code;
    logic [SEG_W-1:0] dec_seg;

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    assign cur_code = shd_bcd_q[idx_q*4 +: 4];

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] lz_sup;

    // Walk from the most significant digit down; digit 0 is never a candidate.
    always_comb begin : lz_scan
        logic lead;
        lead   = 1'b1;
        lz_sup = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (shd_bcd_q[i*4 +: 4] == 4'd0)) lz_sup[i] = 1'b1;
            lead = lead && ((shd_bcd_q[i*4 +: 4] == 4'd0) || shd_blank_q[i]);
        end
    end

    assign dec_code = lz_sup[idx_q] ? CODE_BLANK : cur_code;
`else
    assign dec_code = cur_code;
`endif

    seg_digit_decode u_dec (
        .code_i  (dec_code),
        .dp_i    (shd_dp_q[idx_q]),
        .blank_i (shd_blank_q[idx_q]),
        .seg_o   (dec_seg)
    );

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        pend_d      = pend_q;
        stg_bcd_d   = stg_bcd_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        shd_bcd_d   = shd_bcd_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        // Commit uses the staging contents from before any same-cycle load.
        if (boundary && pend_q) begin
            shd_bcd_d   = stg_bcd_q;
            shd_dp_d    = stg_dp_q;
            shd_blank_d = stg_blank_q;
            pend_d      = 1'b0;
        end
        if (bus.load) begin
            stg_bcd_d   = bus.bcd_in;
            stg_dp_d    = bus.dp_in;
            stg_blank_d = bus.blank_in;
            pend_d      = 1'b1;
        end

        if (cnt_q < CNT_DEAD) begin
            an_d  = '1;
            seg_d = '1;
        end else begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = dec_seg;
        end
        fd_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            stg_bcd_q   <= BCD_RST;
            stg_dp_q    <= '0;
            stg_blank_q <= '1;
            shd_bcd_q   <= BCD_RST;
            shd_dp_q    <= '0;
            shd_blank_q <= '1;
            seg_q       <= '1;
            an_q        <= '1;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            stg_bcd_q   <= stg_bcd_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            shd_bcd_q   <= shd_bcd_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=8, DEAD_CYC=2 (32-cycle frames).
module tb_seg7_scan_driver;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEAD_CYC = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    typedef struct packed {
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [15:0] bcd;
    } disp_t;

    localparam disp_t D0    = '{blank: 4'h0, dp: 4'h0, bcd: 16'h0000};
    localparam disp_t D1234 = '{blank: 4'h0, dp: 4'h0, bcd: 16'h1234};
    localparam disp_t D5678 = '{blank: 4'h0, dp: 4'h0, bcd: 16'h5678};
    localparam disp_t DA    = '{blank: 4'h0, dp: 4'h0, bcd: 16'h9021};
    localparam disp_t DB    = '{blank: 4'h0, dp: 4'b0001, bcd: 16'h3456};
    localparam disp_t DCODE = '{blank: 4'b1000, dp: 4'b1100, bcd: 16'h88DB};
    localparam disp_t DMIX  = '{blank: 4'h0, dp: 4'b0010, bcd: 16'h7A65};
    localparam disp_t DLZ   = '{blank: 4'h0, dp: 4'h0, bcd: 16'h0070};
    localparam disp_t DZ    = '{blank: 4'h0, dp: 4'b1000, bcd: 16'h0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            4'd11:   return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input disp_t d, input int dig);
        logic [3:0] c;
        c = d.bcd[dig*4 +: 4];
        if (d.blank[dig]) return 8'hFF;
`ifdef SEG_LZ_SUPPRESS_EN
        if (dig > 0 && c == 4'd0) begin
            bit all_lead;
            all_lead = 1'b1;
            for (int j = dig + 1; j < DIGITS; j++)
                if (!(d.bcd[j*4 +: 4] == 4'd0 || d.blank[j])) all_lead = 1'b0;
            if (all_lead) c = 4'hF;
        end
`endif
        return {seg_of(c), ~d.dp[dig]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input disp_t d);
        bus.bcd_in   = d.bcd;
        bus.dp_in    = d.dp;
        bus.blank_in = d.blank;
        bus.load     = 1'b1;
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            step();
            if (bus.frame_done) seen = 1'b1;
        end
        chk("fd_wait", {31'b0, seen}, 32'd1);
    endtask

    // Starts in the frame_done cycle and checks the following FRAME cycles.
    task automatic verify_frame(input string name, input disp_t exp,
                                input int k1, input disp_t d1,
                                input int k2, input disp_t d2);
        logic [3:0] ea;
        logic [7:0] es;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            bus.load = 1'b0;
            if (((k - 1) % SCAN_DIV) < DEAD_CYC) begin
                ea = 4'hF;
                es = 8'hFF;
            end else begin
                ea = ~(4'b0001 << ((k - 1) / SCAN_DIV));
                es = exp_seg(exp, (k - 1) / SCAN_DIV);
            end
            chk({name, "_an"}, {28'b0, bus.an}, {28'b0, ea});
            chk({name, "_seg"}, {24'b0, bus.seg}, {24'b0, es});
            chk({name, "_fd"}, {31'b0, bus.frame_done}, (k == FRAME) ? 32'd1 : 32'd0);
            if (k == k1) drive(d1);
            if (k == k2) drive(d2);
        end
    endtask

    initial begin
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.load     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", {24'b0, bus.seg}, 32'hFF);
        chk("rst_an", {28'b0, bus.an}, 32'hF);
        chk("rst_fd", {31'b0, bus.frame_done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            step();
            chk("dark_after_rst", {24'b0, bus.seg}, 32'hFF);
        end

        drive(D1234);
        step();
        bus.load = 1'b0;
        wait_fd();

        verify_frame("f1_1234", D1234, 12, D5678, 0, D0);
        verify_frame("f2_5678", D5678, 10, DA, 31, DB);
        verify_frame("f3_A", DA, 0, D0, 0, D0);
        verify_frame("f4_B", DB, 5, DCODE, 0, D0);
        verify_frame("f5_codes", DCODE, 5, DMIX, 0, D0);
        verify_frame("f6_mix", DMIX, 5, DLZ, 0, D0);
        verify_frame("f7_lz", DLZ, 5, DZ, 0, D0);
        verify_frame("f8_zero", DZ, 0, D0, 0, D0);

        repeat (5) step();
        chk("pre_rst_an", {28'b0, bus.an}, 32'hE);
        rst = 1'b1;
        #1;
        chk("midrst_an", {28'b0, bus.an}, 32'hF);
        chk("midrst_seg", {24'b0, bus.seg}, 32'hFF);
        chk("midrst_fd", {31'b0, bus.frame_done}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            chk("dark_after_midrst", {24'b0, bus.seg}, 32'hFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
